zbuffer_depth_test: RTL and testbench

//  Successor to the vertex/fragment unpack register stage. Unpacks 256-bit fragment words

---
 rtl/zbuf_pkg.sv | 66 ++++++
 rtl/zbuf_if.sv | 30 +++
 rtl/zbuf_depth_ram.sv | 22 ++
 rtl/zbuffer_depth_test.sv | 193 +++++++++++++++++++
 tb/tb_zbuffer_depth_test.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/zbuf_pkg.sv
// Shared definitions for the z-buffer depth test block: geometry, fragment field
// positions, depth compare encodings and the control FSM states.
package zbuf_pkg;

  localparam int unsigned DATA_W  = 256;
  localparam int unsigned COORD_W = 16;
  localparam int unsigned Z_W     = 16;
  localparam int unsigned COLOR_W = 16;
  localparam int unsigned SCR_W   = 64;
  localparam int unsigned SCR_H   = 64;
  localparam int unsigned CNT_W   = 32;

  localparam int unsigned SCR_XW  = $clog2(SCR_W);
  localparam int unsigned SCR_YW  = $clog2(SCR_H);
  localparam int unsigned ADDR_W  = SCR_XW + SCR_YW;
  localparam int unsigned DEPTH_N = SCR_W * SCR_H;

  // LSB positions of the fields inside a packed fragment word
  localparam int unsigned X_LSB = 240;
  localparam int unsigned Y_LSB = 224;
  localparam int unsigned Z_LSB = 208;
  localparam int unsigned R_LSB = 48;
  localparam int unsigned G_LSB = 32;
  localparam int unsigned B_LSB = 16;

  localparam logic [Z_W-1:0] Z_FAR = {1'b0, {(Z_W-1){1'b1}}};

  typedef enum logic [1:0] {
    DF_LESS   = 2'd0,
    DF_LEQUAL = 2'd1,
    DF_ALWAYS = 2'd2,
    DF_NEVER  = 2'd3
  } depth_func_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [Z_W-1:0]     z;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  // Signed depth comparison of an incoming z against the stored z
  function automatic logic depth_pass(input depth_func_e f,
                                      input logic [Z_W-1:0] z_new,
                                      input logic [Z_W-1:0] z_st);
    logic p;
    p = 1'b0;
    case (f)
      DF_LESS:   p = $signed(z_new) <  $signed(z_st);
      DF_LEQUAL: p = $signed(z_new) <= $signed(z_st);
      DF_ALWAYS: p = 1'b1;
      DF_NEVER:  p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/zbuf_if.sv
// Fragment input and framebuffer-writer output bundle of the z-buffer block.
interface zbuf_if;
  import zbuf_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [1:0]         depth_func;

  logic               out_valid;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [Z_W-1:0]     out_z;
  logic [COLOR_W-1:0] out_red;
  logic [COLOR_W-1:0] out_green;
  logic [COLOR_W-1:0] out_blue;

  modport master (
    output in_valid, in_data, depth_func,
    input  in_ready,
    input  out_valid, out_x, out_y, out_z, out_red, out_green, out_blue
  );

  modport slave (
    input  in_valid, in_data, depth_func,
    output in_ready,
    output out_valid, out_x, out_y, out_z, out_red, out_green, out_blue
  );

endinterface

// File: rtl/zbuf_depth_ram.sv
// On-chip depth store: one write port, one synchronous read-first read port, no reset.
module zbuf_depth_ram
  import zbuf_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [Z_W-1:0]    wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [Z_W-1:0]    rdata
);

  logic [Z_W-1:0] mem [DEPTH_N];

  // Same-address read and write returns the old contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/zbuffer_depth_test.sv
// Fragment unpack plus 3-stage per-pixel depth test against the on-chip depth store,
// with clear sweep control and saturating pass/fail/clip statistics.
module zbuffer_depth_test
  import zbuf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  zbuf_if.slave            bus,
  input  logic             clear_start,
  output logic             busy,
  output logic             clear_done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] clip_cnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              clr_we_c;
  logic              in_ready_q;

  logic              s1_valid_q, s1_clip_q;
  pix_t              s1_pix_q;
  depth_func_e       s1_func_q;
  logic [ADDR_W-1:0] s1_addr_q;

  logic              s2_valid_q;
  pix_t              s2_pix_q;
  depth_func_e       s2_func_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic              s2_fwd_q;
  logic [Z_W-1:0]    s2_fwd_z_q;

  logic              out_valid_q;
  pix_t              out_pix_q;

  logic              accept_c;
  pix_t              in_pix;
  logic              in_clip;
  logic [ADDR_W-1:0] in_addr;
  logic              in_data_unused;
  logic [Z_W-1:0]    ram_rdata;
  logic [Z_W-1:0]    st_z_c;
  logic              pass_c, fail_c, clip_inc_c;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [Z_W-1:0]    ram_wdata;

  // Field extraction from the packed fragment word
  assign in_pix.x = bus.in_data[X_LSB +: COORD_W];
  assign in_pix.y = bus.in_data[Y_LSB +: COORD_W];
  assign in_pix.z = bus.in_data[Z_LSB +: Z_W];
  assign in_pix.r = bus.in_data[R_LSB +: COLOR_W];
  assign in_pix.g = bus.in_data[G_LSB +: COLOR_W];
  assign in_pix.b = bus.in_data[B_LSB +: COLOR_W];
  assign in_data_unused = ^{bus.in_data[Z_LSB-1:R_LSB+COLOR_W], bus.in_data[B_LSB-1:0]};

  // Unsigned compare also catches negative coordinates through the sign bit
  assign in_clip = in_pix.x[COORD_W-1] || (in_pix.x >= COORD_W'(SCR_W)) ||
                   in_pix.y[COORD_W-1] || (in_pix.y >= COORD_W'(SCR_H));
  assign in_addr = {in_pix.y[SCR_YW-1:0], in_pix.x[SCR_XW-1:0]};

  assign accept_c     = bus.in_valid & in_ready_q;
  assign bus.in_ready = in_ready_q;

  // Control FSM: next state and clear-write strobe
  always_comb begin
    state_d  = state_q;
    clr_we_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (clear_start)
          state_d = (s1_valid_q || s2_valid_q || accept_c) ? ST_DRAIN : ST_CLEAR;
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_we_c = 1'b1;
        if (clr_addr_q == ADDR_W'(DEPTH_N - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_we_c ? clr_addr_q + ADDR_W'(1) : '0;
      in_ready_q <= (state_d == ST_RUN);
      busy       <= (state_d != ST_RUN);
      clear_done <= (state_q == ST_CLEAR) && (state_d == ST_RUN);
    end
  end

  // Stage 1: registered fields, clip flag and store address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_clip_q  <= 1'b0;
      s1_pix_q   <= '0;
      s1_func_q  <= DF_LESS;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_clip_q <= in_clip;
        s1_pix_q  <= in_pix;
        s1_func_q <= depth_func_e'(bus.depth_func);
        s1_addr_q <= in_addr;
      end
    end
  end

  // Stage 2: stored depth arrives from the RAM; capture the write in flight
  // when the fragment ahead targets the same pixel, since the RAM reads first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_pix_q   <= '0;
      s2_func_q  <= DF_LESS;
      s2_addr_q  <= '0;
      s2_fwd_q   <= 1'b0;
      s2_fwd_z_q <= '0;
    end else begin
      s2_valid_q <= s1_valid_q & ~s1_clip_q;
      s2_pix_q   <= s1_pix_q;
      s2_func_q  <= s1_func_q;
      s2_addr_q  <= s1_addr_q;
      s2_fwd_q   <= pass_c && (s2_addr_q == s1_addr_q);
      s2_fwd_z_q <= s2_pix_q.z;
    end
  end

  assign st_z_c     = s2_fwd_q ? s2_fwd_z_q : ram_rdata;
  assign pass_c     = s2_valid_q &  depth_pass(s2_func_q, s2_pix_q.z, st_z_c);
  assign fail_c     = s2_valid_q & ~depth_pass(s2_func_q, s2_pix_q.z, st_z_c);
  assign clip_inc_c = s1_valid_q &  s1_clip_q;

  // Clear sweep and pipeline writes never overlap: the pipeline is empty in CLEAR
  assign ram_we    = clr_we_c | pass_c;
  assign ram_waddr = clr_we_c ? clr_addr_q : s2_addr_q;
  assign ram_wdata = clr_we_c ? Z_FAR : s2_pix_q.z;

  zbuf_depth_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (s1_valid_q & ~s1_clip_q),
    .raddr (s1_addr_q),
    .rdata (ram_rdata)
  );

  // Output register towards the framebuffer writer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      out_valid_q <= pass_c;
      if (pass_c) out_pix_q <= s2_pix_q;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_pix_q.x;
  assign bus.out_y     = out_pix_q.y;
  assign bus.out_z     = out_pix_q.z;
  assign bus.out_red   = out_pix_q.r;
  assign bus.out_green = out_pix_q.g;
  assign bus.out_blue  = out_pix_q.b;

  // Saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      clip_cnt <= '0;
    end else begin
      if (pass_c     && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (fail_c     && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
      if (clip_inc_c && (clip_cnt != '1)) clip_cnt <= clip_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_zbuffer_depth_test.sv
// Directed bench for zbuffer_depth_test: clear sweep, compare functions, forwarding,
// clipping, clear with fragments in flight and reset in mid-operation.
module tb_zbuffer_depth_test;
  import zbuf_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear_start;
  logic             busy, clear_done;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, clip_cnt;

  int n_cmp = 0;
  int n_err = 0;

  zbuf_if ifc ();

  zbuffer_depth_test dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc),
    .clear_start (clear_start),
    .busy        (busy),
    .clear_done  (clear_done),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .clip_cnt    (clip_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk(input int x, input int y, input int z,
                                           input int r, input int g, input int b);
    logic [DATA_W-1:0] d;
    d = '0;
    d[X_LSB +: COORD_W] = COORD_W'(x);
    d[Y_LSB +: COORD_W] = COORD_W'(y);
    d[Z_LSB +: Z_W]     = Z_W'(z);
    d[R_LSB +: COLOR_W] = COLOR_W'(r);
    d[G_LSB +: COLOR_W] = COLOR_W'(g);
    d[B_LSB +: COLOR_W] = COLOR_W'(b);
    return d;
  endfunction

  // Presents one fragment for one edge; caller sits 1 time unit after an edge
  task automatic drive(input int x, input int y, input int z, input depth_func_e f);
    ifc.in_valid   = 1'b1;
    ifc.in_data    = mk(x, y, z, x + 1, y + 2, 3);
    ifc.depth_func = f;
    @(posedge clk); #1;
    ifc.in_valid   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    int n, busy_hi;
    logic done_seen;
    rst_n = 1'b0;
    step(3);
    n_cmp++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %0b exp 0", ifc.in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b exp 0", busy); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b exp 0", ifc.out_valid); end
    n_cmp++; if ({pass_cnt, fail_cnt, clip_cnt} !== '0) begin n_err++; $display("FAIL rst_counters: got %0d/%0d/%0d exp 0/0/0", pass_cnt, fail_cnt, clip_cnt); end
    rst_n = 1'b1;
    n = 0; busy_hi = 0; done_seen = 1'b0;
    while (n < 5000 && !done_seen) begin
      step(1); n++;
      if (busy) busy_hi++;
      if (clear_done) done_seen = 1'b1;
    end
    n_cmp++; if (n !== 4096) begin n_err++; $display("FAIL rst_clear_len: got %0d edges exp 4096", n); end
    n_cmp++; if (busy_hi !== 4095) begin n_err++; $display("FAIL rst_busy_len: got %0d exp 4095", busy_hi); end
    step(1);
    n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL rst_done_pulse: got %0b exp 0", clear_done); end
    n_cmp++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %0b exp 1", ifc.in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_after: got %0b exp 0", busy); end
  endtask

  task automatic test_single;
    drive(3, 4, 100, DF_LESS);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL single_lat1: got %0b exp 0", ifc.out_valid); end
    step(1);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL single_lat2: got %0b exp 0", ifc.out_valid); end
    step(1);
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b exp 1", ifc.out_valid); end
    n_cmp++; if ({ifc.out_x, ifc.out_y, ifc.out_z} !== {16'd3, 16'd4, 16'd100})
      begin n_err++; $display("FAIL single_xyz: got %0d,%0d,%0d exp 3,4,100", ifc.out_x, ifc.out_y, ifc.out_z); end
    n_cmp++; if ({ifc.out_red, ifc.out_green, ifc.out_blue} !== {16'd4, 16'd6, 16'd3})
      begin n_err++; $display("FAIL single_rgb: got %0d/%0d/%0d exp 4/6/3", ifc.out_red, ifc.out_green, ifc.out_blue); end
    step(1);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %0b exp 0", ifc.out_valid); end
    n_cmp++; if (pass_cnt !== 32'd1) begin n_err++; $display("FAIL single_pass_cnt: got %0d exp 1", pass_cnt); end
  endtask

  task automatic test_back_to_back;
    drive(5, 5, 50, DF_LESS);
    drive(5, 5, 60, DF_LESS);
    step(1);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_z !== 16'd50)
      begin n_err++; $display("FAIL b2b_first: got v=%0b z=%0d exp v=1 z=50", ifc.out_valid, ifc.out_z); end
    step(1);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_second_fwd: got %0b exp 0", ifc.out_valid); end
    step(1);
    n_cmp++; if (fail_cnt !== 32'd1 || pass_cnt !== 32'd2)
      begin n_err++; $display("FAIL b2b_counts: got pass=%0d fail=%0d exp 2/1", pass_cnt, fail_cnt); end
  endtask

  task automatic test_lequal;
    drive(6, 6, 60, DF_LEQUAL);
    drive(6, 6, 60, DF_LEQUAL);
    step(1);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_z !== 16'd60)
      begin n_err++; $display("FAIL leq_first: got v=%0b z=%0d exp v=1 z=60", ifc.out_valid, ifc.out_z); end
    step(1);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_z !== 16'd60)
      begin n_err++; $display("FAIL leq_second: got v=%0b z=%0d exp v=1 z=60", ifc.out_valid, ifc.out_z); end
    step(1);
    n_cmp++; if (pass_cnt !== 32'd4) begin n_err++; $display("FAIL leq_pass_cnt: got %0d exp 4", pass_cnt); end
    drive(6, 6, 60, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL leq_then_less: got %0b exp 0", ifc.out_valid); end
    n_cmp++; if (fail_cnt !== 32'd2) begin n_err++; $display("FAIL leq_fail_cnt: got %0d exp 2", fail_cnt); end
  endtask

  task automatic test_funcs;
    drive(6, 6, 70, DF_ALWAYS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_z !== 16'd70)
      begin n_err++; $display("FAIL func_always: got v=%0b z=%0d exp v=1 z=70", ifc.out_valid, ifc.out_z); end
    drive(6, 6, 0, DF_NEVER);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL func_never: got %0b exp 0", ifc.out_valid); end
    drive(6, 6, 69, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_z !== 16'd69)
      begin n_err++; $display("FAIL func_after_always: got v=%0b z=%0d exp v=1 z=69", ifc.out_valid, ifc.out_z); end
    drive(7, 7, -5, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_z !== 16'hFFFB)
      begin n_err++; $display("FAIL func_neg_z: got v=%0b z=%0h exp v=1 z=fffb", ifc.out_valid, ifc.out_z); end
    drive(7, 7, 10, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL func_signed_cmp: got %0b exp 0", ifc.out_valid); end
    step(1);
    n_cmp++; if (pass_cnt !== 32'd7 || fail_cnt !== 32'd4)
      begin n_err++; $display("FAIL func_counts: got pass=%0d fail=%0d exp 7/4", pass_cnt, fail_cnt); end
  endtask

  task automatic test_clip;
    int outs;
    outs = 0;
    drive(-1, 0, 1, DF_ALWAYS);
    if (ifc.out_valid) outs++;
    drive(0, 64, 1, DF_ALWAYS);
    for (int i = 0; i < 4; i++) begin
      if (ifc.out_valid) outs++;
      step(1);
    end
    n_cmp++; if (outs !== 0) begin n_err++; $display("FAIL clip_no_out: got %0d outputs exp 0", outs); end
    n_cmp++; if (clip_cnt !== 32'd2) begin n_err++; $display("FAIL clip_cnt: got %0d exp 2", clip_cnt); end
    n_cmp++; if (pass_cnt !== 32'd7) begin n_err++; $display("FAIL clip_pass_cnt: got %0d exp 7", pass_cnt); end
    drive(63, 0, 32000, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL clip_store_x: got %0b exp 1", ifc.out_valid); end
    drive(0, 0, 32000, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL clip_store_y: got %0b exp 1", ifc.out_valid); end
    drive(63, 63, 5, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_x !== 16'd63 || ifc.out_y !== 16'd63)
      begin n_err++; $display("FAIL clip_corner: got v=%0b x=%0d y=%0d exp v=1 x=63 y=63", ifc.out_valid, ifc.out_x, ifc.out_y); end
  endtask

  task automatic test_clear_inflight;
    int n, busy_hi, outs, rdy_bad;
    logic done_seen;
    drive(10, 10, 10, DF_LESS);
    drive(11, 10, 20, DF_LESS);
    clear_start = 1'b1;
    step(1);
    clear_start = 1'b0;
    n = 0; busy_hi = busy ? 1 : 0; outs = ifc.out_valid ? 1 : 0; rdy_bad = 0; done_seen = 1'b0;
    n_cmp++; if (ifc.out_x !== 16'd10) begin n_err++; $display("FAIL clr_first_x: got %0d exp 10", ifc.out_x); end
    while (n < 6000 && !done_seen) begin
      step(1); n++;
      if (busy) busy_hi++;
      if (ifc.out_valid) outs++;
      if (clear_done) done_seen = 1'b1;
      else if (ifc.in_ready) rdy_bad++;
    end
    n_cmp++; if (n !== 4098) begin n_err++; $display("FAIL clr_done_at: got %0d edges exp 4098", n); end
    n_cmp++; if (busy_hi !== 4098) begin n_err++; $display("FAIL clr_busy_len: got %0d exp 4098", busy_hi); end
    n_cmp++; if (outs !== 2) begin n_err++; $display("FAIL clr_drain_outs: got %0d exp 2", outs); end
    n_cmp++; if (rdy_bad !== 0) begin n_err++; $display("FAIL clr_ready_low: got %0d ready cycles exp 0", rdy_bad); end
    n_cmp++; if (pass_cnt !== 32'd12) begin n_err++; $display("FAIL clr_pass_cnt: got %0d exp 12", pass_cnt); end
    step(1);
    drive(10, 10, 32000, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_z !== 16'd32000)
      begin n_err++; $display("FAIL clr_after_a: got v=%0b z=%0d exp v=1 z=32000", ifc.out_valid, ifc.out_z); end
    drive(3, 4, 32000, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL clr_after_b: got %0b exp 1", ifc.out_valid); end
    n_cmp++; if (pass_cnt !== 32'd14) begin n_err++; $display("FAIL clr_pass_final: got %0d exp 14", pass_cnt); end
  endtask

  task automatic test_reset_mid;
    int n, outs;
    logic done_seen;
    drive(1, 1, 5, DF_ALWAYS);
    drive(2, 1, 5, DF_ALWAYS);
    rst_n = 1'b0;
    step(1);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid: got %0b exp 0", ifc.out_valid); end
    n_cmp++; if ({pass_cnt, fail_cnt, clip_cnt} !== '0) begin n_err++; $display("FAIL rmid_counters: got %0d/%0d/%0d exp 0/0/0", pass_cnt, fail_cnt, clip_cnt); end
    step(2);
    rst_n = 1'b1;
    n = 0; outs = 0; done_seen = 1'b0;
    while (n < 5000 && !done_seen) begin
      step(1); n++;
      if (ifc.out_valid) outs++;
      if (clear_done) done_seen = 1'b1;
    end
    n_cmp++; if (n !== 4096) begin n_err++; $display("FAIL rmid_clear_len: got %0d edges exp 4096", n); end
    n_cmp++; if (outs !== 0 || pass_cnt !== 32'd0) begin n_err++; $display("FAIL rmid_dropped: got outs=%0d pass=%0d exp 0/0", outs, pass_cnt); end
    step(1);
    drive(1, 1, 7, DF_LESS);
    step(2);
    n_cmp++; if (ifc.out_valid !== 1'b1 || ifc.out_z !== 16'd7)
      begin n_err++; $display("FAIL rmid_after: got v=%0b z=%0d exp v=1 z=7", ifc.out_valid, ifc.out_z); end
    step(1);
    n_cmp++; if (pass_cnt !== 32'd1) begin n_err++; $display("FAIL rmid_pass_cnt: got %0d exp 1", pass_cnt); end
  endtask

  initial begin
    rst_n          = 1'b0;
    clear_start    = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.in_data    = '0;
    ifc.depth_func = 2'd0;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_lequal();
    test_funcs();
    test_clip();
    test_clear_inflight();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
